// File: rtl/argo_chan_reader.sv
// argo_chan_reader: reader end of an Argo channel.
// Buffers up to DEPTH words from an upstream ivalid/oready stream and serves
// blocking channel reads (rd_req/rd_done) for a go-routine control loop.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   ivalid        upstream word on datain is valid
//   datain        upstream data word
//   oready        block can accept a word this cycle
//   rd_req        read request, held high until rd_done
//   rd_data       word returned by the read, held after rd_done
//   rd_done       one-cycle read-complete pulse
//   count         current buffer occupancy
//   stat_words    (ARGO_CHAN_READER_STATS_EN only) number of pops
//   stat_stall    (ARGO_CHAN_READER_STATS_EN only) WAIT cycles plus refused pushes
//
// Optional feature macro: ARGO_CHAN_READER_STATS_EN adds the two stat ports.
module argo_chan_reader #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ivalid,
    input  logic [WIDTH-1:0]  datain,
    output logic              oready,
    input  logic              rd_req,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_done,
    output logic [ADDR_W:0]   count
`ifdef ARGO_CHAN_READER_STATS_EN
    ,
    output logic [31:0]       stat_words,
    output logic [31:0]       stat_stall
`endif
);

    localparam logic [ADDR_W:0] LP_FULL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [ADDR_W:0]    r_count;
    logic [WIDTH-1:0]   r_rd_data;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;

    assign w_empty = (r_count == '0);
    // Registered count only: no combinational path from ivalid or rd_req.
    assign oready  = ~rst & (r_count != LP_FULL);
    assign w_push  = ivalid & oready;
    assign rd_data = r_rd_data;
    assign count   = r_count;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (rd_req) begin
                    w_state_next = w_empty ? StWait : StDone;
                end
            end
            // Blocking read: rd_req is not rechecked while waiting.
            StWait: begin
                if (!w_empty) begin
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_pop   = 1'b0;
        rd_done = 1'b0;
        case (r_state)
            StIdle:  w_pop   = rd_req & ~w_empty;
            StWait:  w_pop   = ~w_empty;
            StDone:  rd_done = 1'b1;
            default: begin
                w_pop   = 1'b0;
                rd_done = 1'b0;
            end
        endcase
    end

    // Storage has no reset; stale words are unreachable once pointers clear.
    // w_push already excludes reset through oready.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= datain;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W + 1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef ARGO_CHAN_READER_STATS_EN
    logic [31:0] r_stat_words;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_words <= '0;
            r_stat_stall <= '0;
        end else begin
            r_stat_words <= r_stat_words + 32'(w_pop);
            r_stat_stall <= r_stat_stall + 32'(r_state == StWait) + 32'(ivalid & ~oready);
        end
    end

    assign stat_words = r_stat_words;
    assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_argo_chan_reader.sv
// tb_argo_chan_reader: directed self-checking bench for argo_chan_reader.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_argo_chan_reader;

    logic        clk;
    logic        rst;
    logic        ivalid;
    logic [31:0] datain;
    logic        oready;
    logic        rd_req;
    logic [31:0] rd_data;
    logic        rd_done;
    logic [2:0]  count;
`ifdef ARGO_CHAN_READER_STATS_EN
    logic [31:0] stat_words;
    logic [31:0] stat_stall;
`endif

    int total;
    int bad;

    argo_chan_reader #(
        .WIDTH  (32),
        .DEPTH  (4),
        .ADDR_W (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ivalid  (ivalid),
        .datain  (datain),
        .oready  (oready),
        .rd_req  (rd_req),
        .rd_data (rd_data),
        .rd_done (rd_done),
        .count   (count)
`ifdef ARGO_CHAN_READER_STATS_EN
        ,
        .stat_words (stat_words),
        .stat_stall (stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input logic [31:0] first, input int n);
        ivalid = 1'b1;
        for (int i = 0; i < n; i++) begin
            datain = first + 32'(i);
            step();
        end
        ivalid = 1'b0;
    endtask

    // Issue one read and wait (bounded) for rd_done; returns to IDLE afterwards.
    task automatic read_word(output logic [31:0] d, output bit ok);
        ok     = 1'b0;
        d      = '0;
        rd_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rd_done === 1'b1) begin
                ok = 1'b1;
                d  = rd_data;
                break;
            end
        end
        rd_req = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++;
        if (oready !== 1'b0) begin
            bad++;
            $display("FAIL reset_oready: got %b want 0", oready);
        end
        total++;
        if (count !== 3'd0 || rd_done !== 1'b0 || rd_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: got count=%0d done=%b data=%h want 0/0/0",
                     count, rd_done, rd_data);
        end
        rst = 1'b0;
        #1;
        total++;
        if (oready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_oready: got %b want 1", oready);
        end
    endtask

    task automatic test_basic_read();
        ivalid = 1'b1;
        datain = 32'h55;
        step();
        datain = 32'h25;
        step();
        ivalid = 1'b0;
        total++;
        if (count !== 3'd2) begin
            bad++;
            $display("FAIL basic_count2: got %0d want 2", count);
        end
        step();
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        total++;
        if (rd_done !== 1'b1 || rd_data !== 32'h55 || count !== 3'd1) begin
            bad++;
            $display("FAIL basic_read1: got done=%b data=%h count=%0d want 1/55/1",
                     rd_done, rd_data, count);
        end
        step();
        total++;
        if (rd_done !== 1'b0 || rd_data !== 32'h55) begin
            bad++;
            $display("FAIL basic_hold: got done=%b data=%h want 0/55", rd_done, rd_data);
        end
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        total++;
        if (rd_done !== 1'b1 || rd_data !== 32'h25 || count !== 3'd0) begin
            bad++;
            $display("FAIL basic_read2: got done=%b data=%h count=%0d want 1/25/0",
                     rd_done, rd_data, count);
        end
        step();
    endtask

    task automatic test_blocking_read();
        rd_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (rd_done !== 1'b0 || count !== 3'd0) begin
                bad++;
                $display("FAIL block_wait%0d: got done=%b count=%0d want 0/0", i, rd_done, count);
            end
        end
        ivalid = 1'b1;
        datain = 32'hA1;
        step();
        ivalid = 1'b0;
        total++;
        if (rd_done !== 1'b0 || count !== 3'd1) begin
            bad++;
            $display("FAIL block_push_edge: got done=%b count=%0d want 0/1", rd_done, count);
        end
        step();
        total++;
        if (rd_done !== 1'b1 || rd_data !== 32'hA1 || count !== 3'd0) begin
            bad++;
            $display("FAIL block_done: got done=%b data=%h count=%0d want 1/a1/0",
                     rd_done, rd_data, count);
        end
        rd_req = 1'b0;
        step();
        total++;
        if (rd_done !== 1'b0) begin
            bad++;
            $display("FAIL block_single_pulse: got %b want 0", rd_done);
        end
    endtask

    task automatic test_full_backpressure();
        logic [31:0] d;
        bit          ok;
        logic        acc;
        ivalid = 1'b1;
        datain = 32'd1;
        // Upstream model: advance the word only when it was accepted.
        for (int i = 0; i < 7; i++) begin
            acc = oready;
            step();
            if (acc) datain = datain + 32'd1;
        end
        total++;
        if (count !== 3'd4 || oready !== 1'b0 || datain !== 32'd5) begin
            bad++;
            $display("FAIL full_stall: got count=%0d oready=%b next=%0d want 4/0/5",
                     count, oready, datain);
        end
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        total++;
        if (rd_done !== 1'b1 || rd_data !== 32'd1 || count !== 3'd3 || oready !== 1'b1) begin
            bad++;
            $display("FAIL full_pop: got done=%b data=%h count=%0d oready=%b want 1/1/3/1",
                     rd_done, rd_data, count, oready);
        end
        step();
        ivalid = 1'b0;
        total++;
        if (count !== 3'd4) begin
            bad++;
            $display("FAIL full_accept5: got count=%0d want 4", count);
        end
        for (int k = 2; k <= 5; k++) begin
            read_word(d, ok);
            total++;
            if (!ok || d !== 32'(k)) begin
                bad++;
                $display("FAIL full_read%0d: got %h ok=%0d want %h", k, d, ok, 32'(k));
            end
        end
        total++;
        if (count !== 3'd0) begin
            bad++;
            $display("FAIL full_drain: got count=%0d want 0", count);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d;
        bit          ok;
        push_words(32'h10, 2);
        ivalid = 1'b1;
        datain = 32'h77;
        rd_req = 1'b1;
        step();
        ivalid = 1'b0;
        rd_req = 1'b0;
        total++;
        if (rd_done !== 1'b1 || rd_data !== 32'h10 || count !== 3'd2) begin
            bad++;
            $display("FAIL simul_edge: got done=%b data=%h count=%0d want 1/10/2",
                     rd_done, rd_data, count);
        end
        step();
        read_word(d, ok);
        total++;
        if (!ok || d !== 32'h11) begin
            bad++;
            $display("FAIL simul_read1: got %h ok=%0d want 11", d, ok);
        end
        read_word(d, ok);
        total++;
        if (!ok || d !== 32'h77 || count !== 3'd0) begin
            bad++;
            $display("FAIL simul_read2: got %h ok=%0d count=%0d want 77/0", d, ok, count);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bit          ok;
        push_words(32'hB0, 4);
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        total++;
        if (rd_done !== 1'b1 || count !== 3'd3) begin
            bad++;
            $display("FAIL midrst_setup: got done=%b count=%0d want 1/3", rd_done, count);
        end
        rst = 1'b1;
        #1;
        total++;
        if (oready !== 1'b0) begin
            bad++;
            $display("FAIL midrst_oready_low: got %b want 0", oready);
        end
        step();
        total++;
        if (count !== 3'd0 || rd_done !== 1'b0 || rd_data !== 32'h0 || oready !== 1'b0) begin
            bad++;
            $display("FAIL midrst_state: got count=%0d done=%b data=%h oready=%b want 0/0/0/0",
                     count, rd_done, rd_data, oready);
        end
        rst = 1'b0;
        #1;
        total++;
        if (oready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_oready_high: got %b want 1", oready);
        end
        // Reset while blocked in WAIT: no stale read may survive.
        rd_req = 1'b1;
        step();
        step();
        rd_req = 1'b0;
        rst    = 1'b1;
        step();
        rst    = 1'b0;
        push_words(32'hC5, 1);
        step();
        step();
        total++;
        if (rd_done !== 1'b0 || count !== 3'd1) begin
            bad++;
            $display("FAIL waitrst_no_read: got done=%b count=%0d want 0/1", rd_done, count);
        end
        read_word(d, ok);
        total++;
        if (!ok || d !== 32'hC5) begin
            bad++;
            $display("FAIL waitrst_read: got %h ok=%0d want c5", d, ok);
        end
    endtask

`ifdef ARGO_CHAN_READER_STATS_EN
    task automatic test_stats();
        logic [31:0] d;
        bit          ok;
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (stat_words !== 32'd0 || stat_stall !== 32'd0) begin
            bad++;
            $display("FAIL stats_reset: got %0d/%0d want 0/0", stat_words, stat_stall);
        end
        // Read 1: four cycles in WAIT.
        rd_req = 1'b1;
        step();
        step();
        step();
        ivalid = 1'b1;
        datain = 32'hE0;
        step();
        ivalid = 1'b0;
        step();
        rd_req = 1'b0;
        step();
        // Fill, then two refused push cycles.
        push_words(32'hE1, 6);
        read_word(d, ok);
        read_word(d, ok);
        total++;
        if (stat_words !== 32'd3 || stat_stall !== 32'd6) begin
            bad++;
            $display("FAIL stats_counts: got words=%0d stall=%0d want 3/6",
                     stat_words, stat_stall);
        end
    endtask
`endif

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        ivalid = 1'b0;
        datain = '0;
        rd_req = 1'b0;
        test_reset();
        test_basic_read();
        test_blocking_read();
        test_full_backpressure();
        test_simultaneous();
        test_reset_mid();
`ifdef ARGO_CHAN_READER_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
